spad_tdc_top: RTL and testbench

//  Multi-hit time-to-digital converter for a 4x4 SPAD pixel group.
//  A start pulse opens a measurement window. Each gated SPAD trigger is timestamped as coarse clk count plus fine DLL phase.
//  Up to 3 hits per window are stored with their SPAD intensity.

---
 rtl/spad_tdc_top.sv | 137 +++++++++++++
 tb/tb_spad_tdc_top.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spad_tdc_top.sv
// Multi-hit TDC for a 4x4 SPAD group: windowed coarse/fine timestamping of up to
// MAX_HITS gated triggers, streamed out as a valid/ready burst with an interrupt.
module spad_tdc_top #(
  parameter int unsigned MAX_HITS = 3,
  parameter int unsigned SYNC_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] DLL_Phase,
  input  logic        TDC_start,
  input  logic        TDC_trigger,
  input  logic [15:0] TDC_spaden,
  input  logic        TDC_tgate,
  input  logic [14:0] TDC_Range,
  output logic [14:0] TDC_Odata,
  output logic [4:0]  TDC_Oint,
  output logic [1:0]  TDC_Onum,
  output logic        TDC_Olast,
  output logic        TDC_Ovalid,
  input  logic        TDC_Oready,
  output logic        TDC_INT
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t              state, state_nx;
  logic [SYNC_LAT-1:0] trig_sync, gate_sync;
  logic                trig_s, gate_s, trig_prev, start_prev;
  logic                start_rise, hit, hit_take, overflow, last_beat;
  logic [9:0]          coarse, coarse_ts, range_c;
  logic [1:0]          count, beat;
  logic [4:0]          fine, pop;
  logic [31:0]         phase_edge;
  logic [14:0]         hit_data [MAX_HITS];
  logic [4:0]          hit_int  [MAX_HITS];

  assign trig_s     = trig_sync[SYNC_LAT-1];
  assign gate_s     = gate_sync[SYNC_LAT-1];
  assign start_rise = TDC_start && !start_prev;
  assign hit        = (state == RUN) && trig_s && !trig_prev && gate_s;
  assign hit_take   = hit && (count < 2'(MAX_HITS));
  assign range_c    = (TDC_Range > 15'd1023) ? 10'd1023 : TDC_Range[9:0];
  assign overflow   = (state == RUN) && (coarse == range_c);
  assign last_beat  = (beat == count - 2'd1);
  // Timestamp refers back to the unsynchronized trigger edge
  assign coarse_ts  = (coarse >= 10'(SYNC_LAT)) ? coarse - 10'(SYNC_LAT) : '0;

  // Thermometer edge: a 1 whose cyclic lower neighbour is 0
  assign phase_edge = DLL_Phase & ~{DLL_Phase[30:0], DLL_Phase[31]};

  always_comb begin
    fine = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (phase_edge[i-1]) fine = 5'(i - 1);
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      pop = pop + 5'(TDC_spaden[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_sync <= '0;
      gate_sync <= '0;
    end else begin
      trig_sync <= {trig_sync[SYNC_LAT-2:0], TDC_trigger};
      gate_sync <= {gate_sync[SYNC_LAT-2:0], TDC_tgate};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_rise) state_nx = RUN;
      RUN:     if (overflow) state_nx = ((count != '0) || hit_take) ? OUT : IDLE;
      OUT:     if (TDC_Oready && last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b0;
      trig_prev  <= 1'b0;
      coarse     <= '0;
      count      <= '0;
      beat       <= '0;
      for (int unsigned i = 0; i < MAX_HITS; i++) begin
        hit_data[i] <= '0;
        hit_int[i]  <= '0;
      end
    end else begin
      start_prev <= TDC_start;
      trig_prev  <= trig_s;
      case (state)
        IDLE: begin
          if (start_rise) begin
            coarse <= '0;
            count  <= '0;
            beat   <= '0;
          end
        end
        RUN: begin
          coarse <= coarse + 10'd1;
          if (hit_take) begin
            hit_data[count] <= {coarse_ts, fine};
            hit_int[count]  <= pop;
            count           <= count + 2'd1;
          end
        end
        OUT: begin
          if (TDC_Oready && !last_beat) beat <= beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    TDC_Ovalid = (state == OUT);
    TDC_INT    = (state == OUT);
    TDC_Odata  = TDC_Ovalid ? hit_data[beat] : '0;
    TDC_Oint   = TDC_Ovalid ? hit_int[beat]  : '0;
    TDC_Onum   = TDC_Ovalid ? count          : '0;
    TDC_Olast  = TDC_Ovalid && last_beat;
  end

endmodule

// File: tb/tb_spad_tdc_top.sv
// Scoreboard bench for spad_tdc_top: expected beats are queued per window and
// consumed by a monitor on every output handshake.
module tb_spad_tdc_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] DLL_Phase = 32'h0000FFFF;
  logic        TDC_start = 1'b0;
  logic        TDC_trigger = 1'b0;
  logic [15:0] TDC_spaden = '0;
  logic        TDC_tgate = 1'b1;
  logic [14:0] TDC_Range = 15'd31;
  logic [14:0] TDC_Odata;
  logic [4:0]  TDC_Oint;
  logic [1:0]  TDC_Onum;
  logic        TDC_Olast;
  logic        TDC_Ovalid;
  logic        TDC_Oready = 1'b1;
  logic        TDC_INT;

  spad_tdc_top #(.MAX_HITS(3), .SYNC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .DLL_Phase(DLL_Phase), .TDC_start(TDC_start),
    .TDC_trigger(TDC_trigger), .TDC_spaden(TDC_spaden), .TDC_tgate(TDC_tgate),
    .TDC_Range(TDC_Range), .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint),
    .TDC_Onum(TDC_Onum), .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid),
    .TDC_Oready(TDC_Oready), .TDC_INT(TDC_INT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] data;
    logic [4:0]  oint;
    logic [1:0]  onum;
    logic        olast;
  } beat_t;

  beat_t       sb[$];
  logic [14:0] pend_d[$];
  logic [4:0]  pend_i[$];
  int          checks = 0;
  int          failures = 0;
  int          rc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each handshake must match the oldest queued expectation
  always @(negedge clk) begin
    #2;
    if (rst_n && TDC_Ovalid && TDC_Oready) begin
      if (sb.size() == 0) begin
        chk("spurious_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("odata", 32'(TDC_Odata), 32'(e.data));
        chk("oint",  32'(TDC_Oint),  32'(e.oint));
        chk("onum",  32'(TDC_Onum),  32'(e.onum));
        chk("olast", 32'(TDC_Olast), 32'(e.olast));
        chk("int_during_out", 32'(TDC_INT), 32'd1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    rc++;
  endtask

  task automatic wait_rc(input int c);
    while (rc < c) tick();
  endtask

  // After this returns the DUT is in RUN with coarse == 0
  task automatic start_window(input logic [14:0] range);
    TDC_Range = range;
    @(negedge clk);
    TDC_start = 1'b1;
    @(negedge clk);
    TDC_start = 1'b0;
    rc = 0;
  endtask

  // Trigger rises while coarse == c, so the stored coarse timestamp is c
  task automatic hit_at(input int c, input logic [15:0] sp, input logic [4:0] pc,
                        input logic [4:0] fn, input bit keep);
    wait_rc(c);
    TDC_spaden  = sp;
    TDC_trigger = 1'b1;
    tick();
    tick();
    TDC_trigger = 1'b0;
    if (keep) begin
      pend_d.push_back({10'(c), fn});
      pend_i.push_back(pc);
    end
  endtask

  task automatic push_window();
    int m;
    m = (pend_d.size() > 3) ? 3 : pend_d.size();
    for (int k = 0; k < m; k++)
      sb.push_back('{data: pend_d[k], oint: pend_i[k], onum: 2'(m), olast: (k == m - 1)});
    pend_d.delete();
    pend_i.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || TDC_Ovalid) && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_valid_low"}, 32'(TDC_Ovalid), 32'd0);
    chk({tag, "_int_low"}, 32'(TDC_INT), 32'd0);
  endtask

  task automatic pulse_trigger();
    TDC_trigger = 1'b1;
    tick();
    tick();
    TDC_trigger = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #3;
    chk("rst_valid", 32'(TDC_Ovalid), 32'd0);
    chk("rst_int",   32'(TDC_INT),    32'd0);
    chk("rst_data",  32'(TDC_Odata),  32'd0);
    chk("rst_onum",  32'(TDC_Onum),   32'd0);
    chk("rst_olast", 32'(TDC_Olast),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single hit, detected at coarse 10 -> timestamp 8
    start_window(15'd31);
    hit_at(8, 16'h0001, 5'd1, 5'd0, 1'b1);
    push_window();
    wait_rc(31);
    chk("t1_not_yet", 32'(TDC_Ovalid), 32'd0);
    wait_rc(32);
    chk("t1_int", 32'(TDC_INT), 32'd1);
    drain("t1");

    // Three hits, increasing timestamps, fine=4
    DLL_Phase = 32'h000FFFF0;
    start_window(15'd31);
    hit_at(4,  16'h0001, 5'd1, 5'd4, 1'b1);
    hit_at(10, 16'h00F1, 5'd5, 5'd4, 1'b1);
    hit_at(16, 16'h0FF1, 5'd9, 5'd4, 1'b1);
    push_window();
    drain("t2");

    // Five hits, only the first three survive; fine=16
    DLL_Phase = 32'hFFFF0000;
    start_window(15'd31);
    hit_at(3,  16'h0001, 5'd1,  5'd16, 1'b1);
    hit_at(8,  16'h00F1, 5'd5,  5'd16, 1'b1);
    hit_at(13, 16'h0FF1, 5'd9,  5'd16, 1'b1);
    hit_at(18, 16'h3FF1, 5'd11, 5'd16, 1'b1);
    hit_at(23, 16'h007F, 5'd7,  5'd16, 1'b1);
    push_window();
    drain("t3");

    // Back-pressure: data must hold while Oready is low
    DLL_Phase = 32'h0000FFFF;
    TDC_Oready = 1'b0;
    start_window(15'd25);
    hit_at(5,  16'h0003, 5'd2, 5'd0, 1'b1);
    hit_at(12, 16'h000F, 5'd4, 5'd0, 1'b1);
    push_window();
    wait_rc(26);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(TDC_Ovalid), 32'd1);
      chk("stall_data",  32'(TDC_Odata),  32'(sb[0].data));
      chk("stall_oint",  32'(TDC_Oint),   32'(sb[0].oint));
      tick();
    end
    TDC_Oready = 1'b1;
    drain("t4");

    // Ignored triggers: before start, with tgate low, after overflow; empty windows
    pulse_trigger();
    chk("pre_start_int", 32'(TDC_INT), 32'd0);
    TDC_tgate = 1'b0;
    start_window(15'd20);
    hit_at(4, 16'h0001, 5'd1, 5'd0, 1'b0);
    wait_rc(22);
    chk("nogate_valid", 32'(TDC_Ovalid), 32'd0);
    chk("nogate_int",   32'(TDC_INT),    32'd0);
    TDC_tgate = 1'b1;
    start_window(15'd10);
    wait_rc(12);
    pulse_trigger();
    chk("post_ovf_int", 32'(TDC_INT), 32'd0);
    start_window(15'd0);
    hit_at(0, 16'h0001, 5'd1, 5'd0, 1'b0);
    wait_rc(8);
    chk("range0_valid", 32'(TDC_Ovalid), 32'd0);

    // Range above 1023 clamps to 1023
    start_window(15'd2000);
    hit_at(5, 16'h0001, 5'd1, 5'd0, 1'b1);
    push_window();
    wait_rc(1023);
    chk("clamp_not_yet", 32'(TDC_Ovalid), 32'd0);
    wait_rc(1024);
    chk("clamp_out", 32'(TDC_Ovalid), 32'd1);
    drain("clamp");

    // Reset during OUT aborts at once, then a fresh window works
    TDC_Oready = 1'b0;
    start_window(15'd15);
    hit_at(3, 16'h0001, 5'd1, 5'd0, 1'b1);
    push_window();
    wait_rc(16);
    chk("pre_rst_valid", 32'(TDC_Ovalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(TDC_Ovalid), 32'd0);
    chk("async_rst_int",   32'(TDC_INT),    32'd0);
    sb.delete();
    TDC_Oready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    DLL_Phase = 32'hFFFF0000;
    start_window(15'd20);
    hit_at(6, 16'h00FF, 5'd8, 5'd16, 1'b1);
    push_window();
    drain("t6");

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
